// File: rtl/mvm_result_serializer.sv
// Two-slot result buffer that serializes each captured 10-row dot-product set onto a valid/ready stream.
// Optional build macro MVM_SER_OVF_STICKY_EN: sticky overflow flag plus 8-bit saturating dropCnt output.
module mvm_result_serializer #(
  parameter int IN_WIDTH  = 16,
  parameter int RES_WIDTH = 2*IN_WIDTH+4,
  parameter int NUM_ROWS  = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          resReady,
  input  logic                          resSetNo,
  input  logic [NUM_ROWS*RES_WIDTH-1:0] resData,
  output logic [RES_WIDTH-1:0]          outData,
  output logic [3:0]                    outIdx,
  output logic                          outSetNo,
  output logic                          outLast,
  output logic                          outValid,
  input  logic                          outReady,
  output logic [1:0]                    bufCount,
`ifdef MVM_SER_OVF_STICKY_EN
  output logic                          overflow,
  output logic [7:0]                    dropCnt
`else
  output logic                          overflow
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROWS-1);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [3:0]           r_idx;
  logic [3:0]           w_idx_next;
  logic                 r_rd_ptr;
  logic                 r_wr_ptr;
  logic [1:0]           r_count;
  logic                 r_ovf;
  logic [RES_WIDTH-1:0] r_slot [2][NUM_ROWS];
  logic                 r_tag  [2];

  logic w_accept;
  logic w_release;
  logic w_capture;
  logic w_drop;

  // Drain FSM: leaving SEND after outLast only when no set remains, counting a same-cycle capture.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_accept     = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && r_count != 2'd0) w_state_next = ST_SEND;
      end
      ST_SEND: begin
        if (enable && outReady) begin
          w_accept = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_release  = 1'b1;
            w_idx_next = 4'd0;
            if (r_count == 2'd1 && !resReady) w_state_next = ST_IDLE;
          end else begin
            w_idx_next = r_idx + 4'd1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // A full buffer still accepts a new set when a slot frees in the same cycle.
  assign w_capture = resReady && (r_count != 2'd2 || w_release);
  assign w_drop    = resReady && r_count == 2'd2 && !w_release;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= 4'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      if (w_release) r_rd_ptr <= ~r_rd_ptr;
      if (w_capture) r_wr_ptr <= ~r_wr_ptr;
      case ({w_capture, w_release})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int k = 0; k < NUM_ROWS; k++) begin
        r_slot[r_wr_ptr][k] <= resData[k*RES_WIDTH +: RES_WIDTH];
      end
      r_tag[r_wr_ptr] <= resSetNo;
    end
  end

`ifdef MVM_SER_OVF_STICKY_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_ovf <= r_ovf | w_drop;
      if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign dropCnt = r_drop_cnt;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ovf <= 1'b0;
    else        r_ovf <= w_drop;
  end
`endif

  // Stream outputs are forced to zero outside SEND so reset and idle values are clean.
  assign outValid = (r_state == ST_SEND);
  assign outData  = outValid ? r_slot[r_rd_ptr][r_idx] : '0;
  assign outIdx   = r_idx;
  assign outSetNo = outValid ? r_tag[r_rd_ptr] : 1'b0;
  assign outLast  = outValid && (r_idx == LAST_IDX);
  assign bufCount = r_count;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_mvm_result_serializer.sv
// Directed bench for mvm_result_serializer: capture, stream, back-pressure, overflow, same-cycle release, reset.
module tb_mvm_result_serializer;

  localparam int IN_WIDTH  = 16;
  localparam int RES_WIDTH = 2*IN_WIDTH+4;
  localparam int NUM_ROWS  = 10;

  logic                          clk;
  logic                          reset;
  logic                          enable;
  logic                          resReady;
  logic                          resSetNo;
  logic [NUM_ROWS*RES_WIDTH-1:0] resData;
  logic [RES_WIDTH-1:0]          outData;
  logic [3:0]                    outIdx;
  logic                          outSetNo;
  logic                          outLast;
  logic                          outValid;
  logic                          outReady;
  logic [1:0]                    bufCount;
  logic                          overflow;
`ifdef MVM_SER_OVF_STICKY_EN
  logic [7:0]                    dropCnt;
`endif

  int compared;
  int mismatched;

  mvm_result_serializer #(
    .IN_WIDTH (IN_WIDTH),
    .RES_WIDTH(RES_WIDTH),
    .NUM_ROWS (NUM_ROWS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .resReady(resReady),
    .resSetNo(resSetNo),
    .resData (resData),
    .outData (outData),
    .outIdx  (outIdx),
    .outSetNo(outSetNo),
    .outLast (outLast),
    .outValid(outValid),
    .outReady(outReady),
    .bufCount(bufCount),
`ifdef MVM_SER_OVF_STICKY_EN
    .overflow(overflow),
    .dropCnt (dropCnt)
`else
    .overflow(overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element k of a set built from base is base + k + 1.
  function automatic logic [NUM_ROWS*RES_WIDTH-1:0] mk(input logic [RES_WIDTH-1:0] base);
    logic [NUM_ROWS*RES_WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_ROWS; k++) v[k*RES_WIDTH +: RES_WIDTH] = base + RES_WIDTH'(k + 1);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic setno, input int idx, input logic [RES_WIDTH-1:0] base);
    chk({tag, ".valid"}, 64'(outValid), 64'd1);
    chk({tag, ".idx"},   64'(outIdx),   64'(idx));
    chk({tag, ".data"},  64'(outData),  64'(base + RES_WIDTH'(idx + 1)));
    chk({tag, ".setno"}, 64'(outSetNo), 64'(setno));
    chk({tag, ".last"},  64'(outLast),  64'(idx == NUM_ROWS-1));
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, ".valid"}, 64'(outValid), 64'd0);
    chk({tag, ".idx"},   64'(outIdx),   64'd0);
    chk({tag, ".data"},  64'(outData),  64'd0);
    chk({tag, ".setno"}, 64'(outSetNo), 64'd0);
    chk({tag, ".last"},  64'(outLast),  64'd0);
    chk({tag, ".count"}, 64'(bufCount), 64'd0);
    chk({tag, ".ovf"},   64'(overflow), 64'd0);
`ifdef MVM_SER_OVF_STICKY_EN
    chk({tag, ".dropcnt"}, 64'(dropCnt), 64'd0);
`endif
  endtask

  task automatic pulse(input logic [RES_WIDTH-1:0] base, input logic tag);
    resReady = 1'b1;
    resData  = mk(base);
    resSetNo = tag;
    step();
    resReady = 1'b0;
  endtask

  initial begin
    int k;
    compared   = 0;
    mismatched = 0;
    reset    = 1'b0;
    enable   = 1'b1;
    resReady = 1'b0;
    resSetNo = 1'b0;
    resData  = '0;
    outReady = 1'b0;
    step();
    step();
    reset_vals("rst");
    reset = 1'b1;
    step();

    // Single set, E_k = k+1, continuous ready
    outReady = 1'b1;
    pulse(36'h0, 1'b0);
    chk("t1.count_cap", 64'(bufCount), 64'd1);
    chk("t1.valid_lat", 64'(outValid), 64'd0);
    step();
    for (int i = 0; i < NUM_ROWS; i++) begin
      beat("t1", 1'b0, i, 36'h0);
      chk("t1.count", 64'(bufCount), 64'd1);
      step();
    end
    chk("t1.idle_valid", 64'(outValid), 64'd0);
    chk("t1.idle_count", 64'(bufCount), 64'd0);

    // Enable low freezes, then ready toggles 1,0,...
    outReady = 1'b0;
    pulse(36'h100, 1'b1);
    step();
    enable   = 1'b0;
    outReady = 1'b1;
    beat("t2.en0a", 1'b1, 0, 36'h100);
    step();
    beat("t2.en0b", 1'b1, 0, 36'h100);
    step();
    enable = 1'b1;
    k = 0;
    for (int c = 0; c < 19; c++) begin
      outReady = (c % 2 == 0);
      beat("t2.bp", 1'b1, k, 36'h100);
      step();
      if (c % 2 == 0) k++;
    end
    chk("t2.beats", 64'(k), 64'd10);
    chk("t2.idle_valid", 64'(outValid), 64'd0);
    chk("t2.idle_count", 64'(bufCount), 64'd0);

    // Two sets buffered, then 20 contiguous beats
    outReady = 1'b0;
    pulse(36'h200, 1'b0);
    pulse(36'h300, 1'b1);
    chk("t3.count2", 64'(bufCount), 64'd2);
    chk("t3.ovf0", 64'(overflow), 64'd0);
    beat("t3.hold", 1'b0, 0, 36'h200);
    outReady = 1'b1;
    for (int j = 0; j < 2*NUM_ROWS; j++) begin
      if (j < NUM_ROWS) beat("t3.a", 1'b0, j, 36'h200);
      else              beat("t3.b", 1'b1, j - NUM_ROWS, 36'h300);
      step();
    end
    chk("t3.idle_valid", 64'(outValid), 64'd0);
    chk("t3.idle_count", 64'(bufCount), 64'd0);

    // Third set dropped while full
    outReady = 1'b0;
    pulse(36'h400, 1'b0);
    pulse(36'h500, 1'b1);
    pulse(36'h600, 1'b0);
    chk("t4.ovf", 64'(overflow), 64'd1);
    chk("t4.count", 64'(bufCount), 64'd2);
    step();
`ifdef MVM_SER_OVF_STICKY_EN
    chk("t4.ovf_after", 64'(overflow), 64'd1);
    chk("t4.dropcnt", 64'(dropCnt), 64'd1);
`else
    chk("t4.ovf_after", 64'(overflow), 64'd0);
`endif
    outReady = 1'b1;
    for (int j = 0; j < 2*NUM_ROWS; j++) begin
      if (j < NUM_ROWS) beat("t4.a", 1'b0, j, 36'h400);
      else              beat("t4.b", 1'b1, j - NUM_ROWS, 36'h500);
      step();
    end
    chk("t4.idle_valid", 64'(outValid), 64'd0);
    chk("t4.idle_count", 64'(bufCount), 64'd0);

    // Full buffer with capture coinciding with the accepted outLast
    outReady = 1'b0;
    pulse(36'h700, 1'b0);
    pulse(36'h800, 1'b1);
    chk("t5.count2", 64'(bufCount), 64'd2);
    outReady = 1'b1;
    for (int i = 0; i < NUM_ROWS-1; i++) begin
      beat("t5.a", 1'b0, i, 36'h700);
      step();
    end
    beat("t5.alast", 1'b0, NUM_ROWS-1, 36'h700);
    pulse(36'h900, 1'b0);
`ifdef MVM_SER_OVF_STICKY_EN
    chk("t5.ovf", 64'(overflow), 64'd1);
    chk("t5.dropcnt", 64'(dropCnt), 64'd1);
`else
    chk("t5.ovf", 64'(overflow), 64'd0);
`endif
    chk("t5.count", 64'(bufCount), 64'd2);
    for (int j = 0; j < 2*NUM_ROWS; j++) begin
      if (j < NUM_ROWS) beat("t5.b", 1'b1, j, 36'h800);
      else              beat("t5.c", 1'b0, j - NUM_ROWS, 36'h900);
      step();
    end
    chk("t5.idle_valid", 64'(outValid), 64'd0);
    chk("t5.idle_count", 64'(bufCount), 64'd0);

    // Asynchronous reset mid-stream at idx 4
    pulse(36'hA00, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      beat("t6.pre", 1'b1, i, 36'hA00);
      step();
    end
    beat("t6.idx4", 1'b1, 4, 36'hA00);
    reset = 1'b0;
    #1;
    reset_vals("t6.rst");
    step();
    reset = 1'b1;
    step();
    pulse(36'hB00, 1'b0);
    chk("t6.count_cap", 64'(bufCount), 64'd1);
    step();
    for (int i = 0; i < NUM_ROWS; i++) begin
      beat("t6.new", 1'b0, i, 36'hB00);
      step();
    end
    chk("t6.idle_valid", 64'(outValid), 64'd0);
    chk("t6.idle_count", 64'(bufCount), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mvm_result_serializer.md
# mvm_result_serializer

Consumer end of the 10-row matrix-vector multiplier's result interface. Captures the ten parallel dot-product results (E0..E9) on each result-ready pulse into a two-entry result buffer. Drains each captured set as an ordered stream of ten elements over a valid/ready handshake toward downstream storage or the bus interface. Decouples the multiplier's fixed-rate output from a back-pressuring consumer and flags any result set lost to overflow.

## Interface
Parameters:
- IN_WIDTH, 16, multiplier input element width
- RES_WIDTH, 2*IN_WIDTH+4, width of one result element
- NUM_ROWS, 10, result elements per set

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  gates the output side only; low freezes the stream state (out_* held)
- resReady  in  1  one-cycle pulse: E bus holds a valid result set
- resSetNo  in  1  set tag accompanying resReady
- resData  in  NUM_ROWS*RES_WIDTH  packed results, E0 in bits [RES_WIDTH-1:0]
- outData  out  RES_WIDTH  current stream element
- outIdx  out  4  row index of outData, 0..NUM_ROWS-1
- outSetNo  out  1  tag of the set being drained
- outLast  out  1  high with the element where outIdx = NUM_ROWS-1
- outValid  out  1  stream element valid
- outReady  in  1  downstream accepts when outValid & outReady & enable
- bufCount  out  2  captured sets held, 0..2
- overflow  out  1  result set dropped

## Operation
- Buffer: two set slots with a write pointer, a read pointer and a count (0..2). Each slot stores NUM_ROWS results plus the set tag.
- Capture: on a resReady cycle with count < 2, store resData and resSetNo in the write slot, advance the write pointer, and increment count. Capture is independent of enable.
- Drop: on a resReady cycle with count = 2 and no same-cycle release, discard the set and raise overflow. Buffer contents are unchanged.
- Drain FSM states:
  - IDLE: outValid = 0. Go to SEND when count > 0.
  - SEND: outValid = 1. outData = slot[rd][idx], outIdx = idx, outSetNo = slot tag.
  - On an accepted beat with idx < NUM_ROWS-1: idx++.
  - On an accepted beat with idx = NUM_ROWS-1 (outLast): release the slot, advance the read pointer, decrement count, set idx = 0. Stay in SEND if another set remains, otherwise return to IDLE.
- Simultaneous capture and release in the same cycle: count is unchanged. A capture with count = 2 succeeds into the freed slot, with no overflow.
- outData, outIdx and outSetNo are stable while outValid & !(outReady & enable).
- Widths: data is passed through bit-exact. No arithmetic is performed on results.

## Timing
- Reset values: outData = 0, outIdx = 0, outSetNo = 0, outLast = 0, outValid = 0, bufCount = 0, overflow = 0, FSM = IDLE, pointers = 0.
- Latency: a resReady at edge N with an empty buffer gives outValid = 1 and element 0 after edge N+1 (one-cycle latency).
- Throughput: one element per cycle with outReady = 1 and enable = 1, so a set takes 10 cycles. With continuous ready, the next set's element 0 follows the previous outLast with no bubble.
- Without the configuration macro, overflow is a one-cycle pulse in the cycle after the dropped resReady.
- Reset asserted mid-stream: everything is cleared asynchronously and buffered sets are lost. The first capture after reset release behaves as from an empty buffer.
- enable = 0 during SEND: no beat completes even if outReady = 1. Captures still occur.

## Configuration
- MVM_SER_OVF_STICKY_EN defined:
  - overflow is sticky. It sets on a drop and holds until reset.
  - A drop counter register, dropCnt, is added as an output (8 bits, saturating at 255).
- Not defined: overflow is a single-cycle pulse per drop. No dropCnt port or register exists.

## Test plan
- Single set, E_k = k+1, outReady = 1: one resReady gives outIdx 0..9 with outData 1..10 on 10 consecutive cycles. outLast is high only at idx 9. bufCount goes 1 then 0.
- Back-pressure: outReady toggles 1,0,1,0 during a set. Each element is held stable while stalled. All 10 are delivered in order, with no duplication.
- Two back-to-back sets, tags 0 and 1, outReady = 0: bufCount = 2. Releasing outReady streams tag 0 then tag 1 with 20 contiguous beats.
- Overflow: three resReady pulses with outReady = 0. The third set is dropped, with an overflow pulse, or sticky plus dropCnt = 1 when MVM_SER_OVF_STICKY_EN is defined. Draining yields only sets 1 and 2.
- Full buffer plus same-cycle release: resReady coincides with the accepted outLast while count = 2. No overflow occurs, count stays 2, and the new set is drained third.
- Reset mid-stream at idx 4: all outputs return to their reset values immediately. A new resReady afterwards streams from idx 0.
